// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage with a skid buffer: registered in_ready, bubble control
// on empty, synchronous flush, and a saturating back-pressure counter.
module pipe_stage_skid #(
  parameter int                 DATA_W      = 64,
  parameter int                 CTRL_W      = 24,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   main_data_reg, skid_data_reg;
  logic [CTRL_W-1:0]   main_ctrl_reg, skid_ctrl_reg;
  logic [1:0]          occupancy_reg, occupancy_next;
  logic [15:0]         stall_cnt_reg, stall_cnt_next;

  logic main_valid, skid_valid;
  logic accept, pop;
  logic load_main_in, load_main_skid, load_skid_in;

  // Valid bits are decoded from the state so skid-without-main cannot be represented.
  assign main_valid = (state_reg != EMPTY);
  assign skid_valid = (state_reg == FULL);

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data_reg;
  assign out_ctrl  = main_valid ? main_ctrl_reg : BUBBLE_CTRL;
  assign occupancy = occupancy_reg;
  assign stall_cnt = stall_cnt_reg;

  assign accept = in_valid & in_ready;
  assign pop    = main_valid & out_ready;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next   = FULL;
            load_skid_in = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    occupancy_next = 2'd0;
    case (state_next)
      ONE:     occupancy_next = 2'd1;
      FULL:    occupancy_next = 2'd2;
      default: occupancy_next = 2'd0;
    endcase
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (main_valid && !out_ready && !flush && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      occupancy_reg <= 2'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      occupancy_reg <= occupancy_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Payload registers never clear on flush; only the valid state does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
    end else if (load_main_in) begin
      main_data_reg <= in_data;
      main_ctrl_reg <= in_ctrl;
    end else if (load_main_skid) begin
      main_data_reg <= skid_data_reg;
      main_ctrl_reg <= skid_ctrl_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
    end else if (load_skid_in) begin
      skid_data_reg <= in_data;
      skid_ctrl_reg <= in_ctrl;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a queue model checked every negedge plus
// hand-computed literal expectations for streaming, stall, flush, reset and saturation.
module tb_pipe_stage_skid;
  localparam int DATA_W = 64;
  localparam int CTRL_W = 24;
  localparam logic [CTRL_W-1:0] BUBBLE = 24'hBBBBBB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;

  int errors = 0;
  int checks = 0;
  logic seen_c = 1'b0;

  logic [DATA_W-1:0] q_data[$];
  logic [CTRL_W-1:0] q_ctrl[$];
  int m_stall = 0;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_CTRL(BUBBLE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two entries; flush and reset empty it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data.delete();
      q_ctrl.delete();
      m_stall <= 0;
    end else if (flush) begin
      q_data.delete();
      q_ctrl.delete();
    end else begin
      if (q_data.size() > 0 && !out_ready && m_stall < 65535) m_stall <= m_stall + 1;
      if (in_valid && q_data.size() < 2) begin
        if (out_ready && q_data.size() > 0) begin
          $display("pop    data=%h", q_data[0]);
          void'(q_data.pop_front());
          void'(q_ctrl.pop_front());
        end
        q_data.push_back(in_data);
        q_ctrl.push_back(in_ctrl);
        $display("accept data=%h", in_data);
      end else if (out_ready && q_data.size() > 0) begin
        $display("pop    data=%h", q_data[0]);
        void'(q_data.pop_front());
        void'(q_ctrl.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    check("m_out_valid", {63'd0, out_valid}, {63'd0, q_data.size() > 0});
    check("m_in_ready", {63'd0, in_ready}, {63'd0, q_data.size() < 2});
    check("m_occupancy", {62'd0, occupancy}, 64'(q_data.size()));
    check("m_stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
    if (q_data.size() > 0) begin
      check("m_out_data", out_data, q_data[0]);
      check("m_out_ctrl", {40'd0, out_ctrl}, {40'd0, q_ctrl[0]});
    end else begin
      check("m_bubble_ctrl", {40'd0, out_ctrl}, {40'd0, BUBBLE});
    end
    if (out_valid && out_data == 64'hCCCC) seen_c = 1'b1;
  end

  task automatic drive(input logic v, input logic [63:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = d[23:0] | 24'h010000;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_occupancy", {62'd0, occupancy}, 64'd0);
    check("rst_out_ctrl", {40'd0, out_ctrl}, {40'd0, BUBBLE});
    check("rst_stall", {48'd0, stall_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 1'b1, 1'b0);
      step();
      check("stream_data", out_data, 64'(i));
      check("stream_occ", {62'd0, occupancy}, 64'd1);
    end
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    step();
    check("stream_drain", {63'd0, out_valid}, 64'd0);

    // Back-pressure: A, B, then stall; four stalled edges in total.
    drive(1'b1, 64'h1111, 1'b0, 1'b0); step();
    drive(1'b1, 64'h2222, 1'b0, 1'b0); step();
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", out_data, 64'h1111);
    end
    check("bp_occ", {62'd0, occupancy}, 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_stall", {48'd0, stall_cnt}, 64'd4);
    drive(1'b0, 64'd0, 1'b1, 1'b0); step();
    check("bp_release_b", out_data, 64'h2222);
    step();
    check("bp_empty", {63'd0, out_valid}, 64'd0);

    // Accept and pop together while holding one entry.
    drive(1'b1, 64'h3333, 1'b0, 1'b0); step();
    drive(1'b1, 64'h4444, 1'b1, 1'b0); step();
    check("ap_occ", {62'd0, occupancy}, 64'd1);
    check("ap_data", out_data, 64'h4444);
    drive(1'b0, 64'd0, 1'b1, 1'b0); step();

    // Flush while full with C offered.
    drive(1'b1, 64'h5555, 1'b0, 1'b0); step();
    drive(1'b1, 64'h6666, 1'b0, 1'b0); step();
    check("fl_full", {62'd0, occupancy}, 64'd2);
    drive(1'b1, 64'hCCCC, 1'b0, 1'b1); step();
    check("fl_valid", {63'd0, out_valid}, 64'd0);
    check("fl_ctrl", {40'd0, out_ctrl}, {40'd0, BUBBLE});
    check("fl_occ", {62'd0, occupancy}, 64'd0);
    check("fl_stall", {48'd0, stall_cnt}, 64'd5);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    step(); step(); step();
    check("fl_c_never", {63'd0, seen_c}, 64'd0);

    // Asynchronous reset pulse mid-cycle while full and stalled.
    drive(1'b1, 64'h7777, 1'b0, 1'b0); step();
    drive(1'b1, 64'h8888, 1'b0, 1'b0); step();
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    check("ar_full", {62'd0, occupancy}, 64'd2);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {63'd0, out_valid}, 64'd0);
    check("ar_occ", {62'd0, occupancy}, 64'd0);
    check("ar_stall", {48'd0, stall_cnt}, 64'd0);
    check("ar_ready", {63'd0, in_ready}, 64'd1);
    check("ar_ctrl", {40'd0, out_ctrl}, {40'd0, BUBBLE});
    #3 rst = 1'b0;

    // First accept right after reset release.
    drive(1'b1, 64'h9999, 1'b0, 1'b0); step();
    check("post_rst_accept", out_data, 64'h9999);
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);

    // Saturation of the stall counter.
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (65534) step();
    check("sat_fffe", {48'd0, stall_cnt}, 64'hFFFE);
    step();
    check("sat_ffff", {48'd0, stall_cnt}, 64'hFFFF);
    repeat (5) step();
    check("sat_nowrap", {48'd0, stall_cnt}, 64'hFFFF);
    check("sat_data", out_data, 64'h9999);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
